// File: rtl/small_calc_pkg.sv
// small_calc_pkg: shared state codes and op encodings for the small calculator
package small_calc_pkg;
  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] CALC = 4'd2;
  localparam logic [3:0] DONE = 4'd3;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;
endpackage

// File: rtl/small_calc_alu.sv
// small_calc_alu: combinational 4-bit ALU, all results wrap mod 16
module small_calc_alu
  import small_calc_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  output logic [3:0] y
);
  // select one of the four operations; no carry or borrow is kept
  always_comb begin
    y = op == OP_ADD ? a + b :
        op == OP_SUB ? a - b :
        op == OP_AND ? a & b : a ^ b;
  end
endmodule

// File: rtl/small_calc_top.sv
// small_calc_top: three-state calculator that latches operands on go_calc and registers the ALU result
module small_calc_top
  import small_calc_pkg::*;
(
  input  logic       go_calc,
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] op,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       done,
  output logic [3:0] out,
  output logic [3:0] CS
);
  logic [3:0] state_q, state_d;
  logic [3:0] x_q, x_d, y_q, y_d, out_q, out_d, alu_y;
  logic [1:0] op_q, op_d;
  logic       start;
  small_calc_alu u_alu (
    .a  (x_q),
    .b  (y_q),
    .op (op_q),
    .y  (alu_y)
  );
  // next state, operand capture on an accepted start, result capture leaving CALC
  always_comb begin
    start   = state_q == IDLE && go_calc;
    state_d = state_q == IDLE ? (go_calc ? CALC : IDLE) :
              state_q == CALC ? DONE : IDLE;
    x_d     = start ? x : x_q;
    y_d     = start ? y : y_q;
    op_d    = start ? op : op_q;
    out_d   = state_q == CALC ? alu_y : out_q;
  end
  // all state clears immediately when rst drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end
  assign done = state_q == DONE;
  assign out  = out_q;
  assign CS   = state_q;
endmodule

// File: tb/tb_small_calc_top.sv
// tb_small_calc_top: directed scoreboard bench for the small calculator
module tb_small_calc_top;
  logic       clk = 1'b0;
  logic       rst, go_calc, done;
  logic [1:0] op;
  logic [3:0] x, y, out, CS;
  int         checks = 0;
  int         errors = 0;
  int         dcount;
  logic [3:0] sb[$];
  logic [3:0] seq_exp;

  always #5 clk = ~clk;

  small_calc_top dut (
    .go_calc (go_calc),
    .clk     (clk),
    .rst     (rst),
    .op      (op),
    .x       (x),
    .y       (y),
    .done    (done),
    .out     (out),
    .CS      (CS)
  );

  function automatic logic [3:0] model(input int a, input int b, input int o);
    int r;
    case (o)
      0:       r = (a + b) % 16;
      1:       r = (a - b + 16) % 16;
      2:       r = a & b;
      default: r = a ^ b;
    endcase
    return r[3:0];
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // called at a negedge in IDLE; one full transaction, optionally disturbing inputs during CALC
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o, input bit scramble);
    int n;
    logic [3:0] e;
    x = a; y = b; op = o; go_calc = 1'b1;
    sb.push_back(model(int'(a), int'(b), int'(o)));
    @(negedge clk);
    go_calc = 1'b0;
    chk("calc_cs", CS, 4'd2);
    chk("calc_done", {3'b0, done}, 4'd0);
    if (scramble) begin
      x = ~a; y = b + 4'd5; op = o + 2'd1;
    end
    n = 1;
    while (!done && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n[3:0], 4'd2);
    chk("done_cs", CS, 4'd3);
    e = sb.pop_front();
    chk("result", out, e);
    @(negedge clk);
    chk("idle_cs", CS, 4'd0);
    chk("idle_done", {3'b0, done}, 4'd0);
    chk("out_hold", out, e);
  endtask

  initial begin
    rst = 1'b1; go_calc = 1'b0; op = 2'd0; x = 4'd0; y = 4'd0;
    #2 rst = 1'b0;
    #1;
    chk("rst_cs", CS, 4'd0);
    chk("rst_done", {3'b0, done}, 4'd0);
    chk("rst_out", out, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_stay", CS, 4'd0);
    end
    // mid-run reset while in DONE
    x = 4'd9; y = 4'd3; op = 2'd0; go_calc = 1'b1;
    @(negedge clk);
    go_calc = 1'b0;
    @(negedge clk);
    chk("pre_rst_cs", CS, 4'd3);
    chk("pre_rst_out", out, 4'd12);
    rst = 1'b0;
    #1;
    chk("midrst_cs", CS, 4'd0);
    chk("midrst_done", {3'b0, done}, 4'd0);
    chk("midrst_out", out, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_cs", CS, 4'd0);
    // each op with x=12, y=2
    for (int o = 0; o < 4; o++) run_op(4'd12, 4'd2, 2'(o), 1'b0);
    // wraparound cases
    run_op(4'd15, 4'd1, 2'd0, 1'b0);
    run_op(4'd2, 4'd3, 2'd1, 1'b0);
    run_op(4'd7, 4'd7, 2'd3, 1'b0);
    // inputs disturbed during CALC must not affect the result
    run_op(4'd3, 4'd9, 2'd1, 1'b1);
    run_op(4'd10, 4'd6, 2'd2, 1'b1);
    // go_calc held high: one result every three cycles
    x = 4'd9; y = 4'd4; op = 2'd0; go_calc = 1'b1; dcount = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      seq_exp = (i % 3 == 0) ? 4'd2 : (i % 3 == 1) ? 4'd3 : 4'd0;
      chk("held_cs", CS, seq_exp);
      chk("held_done", {3'b0, done}, {3'b0, seq_exp == 4'd3});
      if (done) begin
        dcount++;
        chk("held_out", out, 4'd13);
      end
    end
    go_calc = 1'b0;
    chk("held_count", 4'(dcount), 4'd3);
    // reset during CALC aborts the operation
    x = 4'd5; y = 4'd6; op = 2'd0; go_calc = 1'b1;
    @(negedge clk);
    go_calc = 1'b0;
    chk("abort_pre_cs", CS, 4'd2);
    rst = 1'b0;
    #1;
    chk("abort_cs", CS, 4'd0);
    chk("abort_out", out, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_cs_idle", CS, 4'd0);
      chk("abort_no_done", {3'b0, done}, 4'd0);
      chk("abort_out_zero", out, 4'd0);
    end
    // exhaustive sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int o = 0; o < 4; o++)
          run_op(4'(a), 4'(b), 2'(o), 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
